cl_mask_matcher: RTL and testbench
==================================

# cl_mask_matcher

Sparse-operand match unit for the PE datapath of the sparse DNN accelerator. Each cycle it compares a 16-bit weight occupancy bitmask with a 16-bit activation occupancy bitmask. It selects the first two positions, at or after the per-operand start indices, where both operands are nonzero. It reports which compressed (packed) entries of each operand feed the MAC, plus where scanning resumes next cycle. All outputs are packed into one 64-bit registered word for the OpenCL RTL-library wrapper.

## Interface
- No parameters. Mask width is fixed at 16, start indices are 5 bits, and at most 2 matches are selected per cycle.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the output register.
- bitmaskW  in  16  weight occupancy; bit i=1 means dense position i holds a nonzero weight.
- bitmaskA  in  16  activation occupancy, same encoding.
- startIndexW  in  5  first dense position eligible for W (0..16; values >16 are treated as 16).
- startIndexA  in  5  first dense position eligible for A (same rule).
- result  out  64  registered packed result:
  - [15:0] packedBitmaskW
  - [31:16] packedBitmaskA
  - [36:32] nextWStartIndex
  - [38:37] numDenseW
  - [39] 0
  - [44:40] nextAStartIndex
  - [46:45] numDenseA
  - [63:47] 0

## Operation
- Eligibility mask: eligW[i] = (i >= startIndexW); eligA[i] = (i >= startIndexA).
- Match vector: match = bitmaskW & bitmaskA & eligW & eligA.
- Selection:
  - p0 = lowest set bit of match.
  - p1 = lowest set bit of match above p0.
  - Select p0 if it exists, and p1 if it exists; n = number selected (0..2).
- Packed position of a selected p for operand X: k = popcount(bitmaskX[p-1:0]), i.e. the count of set bits strictly below p (k = 0 for p = 0).
  - packedBitmaskX has bit k set for each selected p; all other bits are 0.
  - Compressed indices use the full mask, independent of the start index.
- numDenseW = numDenseA = n.
- Next start indices:
  - If n = 2 and match has any set bit above p1: nextW = nextA = p1+1.
  - Otherwise (fewer than 2 matches, or none remaining after p1): nextW = nextA = 16, the "block exhausted" code.
- No match (n = 0): both packed masks are 0, both numDense fields are 0, both next indices are 16.
- Reserved bits [39] and [63:47] are always 0.
- No internal state other than the output register. Inputs carry no handshake and are sampled every cycle.

## Timing
- Latency 1 cycle: inputs present before rising edge t appear on result after edge t. Fully pipelined, so a new input set is accepted every cycle.
- Combinational path covers the AND, priority-select, two 16-bit prefix popcounts and decode. It must close in one cycle of the kernel clock.
- Reset: on any edge with reset=1, result <= 64'h0 (every field 0, including next indices). The inputs at that edge are discarded.
- The first edge with reset=0 loads normally; there is no recovery bubble.
- Reset asserted mid-stream takes effect at that edge only. Prior results are lost.
- Before the first reset, result is unspecified; the bench must reset first.

## Test plan
- Reset: assert reset for 2 cycles with arbitrary inputs -> result = 64'h0.
- W=FFFF, A=0000, sW=0, sA=0 -> no match; result = 64'h0000_1010_0000_0000.
- W=FFFF, A=FFFF, sW=0, sA=4 -> p=4,5 selected, packed 0x0030 for both, next 6, n=2; result = 64'h0000_4646_0030_0030.
- W=F00F, A=FFFF, sW=0, sA=0 -> p=0,1 selected, next 2; result = 64'h0000_4242_0003_0003.
- W=8001, A=8001, sW=0, sA=0 -> p=0,15 selected, W/A packed 0x0003, none remaining so next 16; result = 64'h0000_5050_0003_0003.
- W=0000, A=0000, sW=4, sA=4 -> result = 64'h0000_1010_0000_0000.
- Back-to-back: apply the four nonzero vectors on consecutive cycles -> each result appears exactly 1 cycle later, in order.
- Mid-stream reset: pulse reset during the sequence -> result = 0 for that cycle only.

Source files
------------

// File: rtl/cl_mask_matcher_if.sv
// Operand/result bundle for the sparse match unit: occupancy masks and start
// indices in, packed 64-bit match descriptor out.
interface cl_mask_matcher_if;
   logic [15:0] bitmaskW;
   logic [15:0] bitmaskA;
   logic [4:0]  startIndexW;
   logic [4:0]  startIndexA;
   logic [63:0] result;

   modport master (
      output bitmaskW, bitmaskA, startIndexW, startIndexA,
      input  result
   );

   modport slave (
      input  bitmaskW, bitmaskA, startIndexW, startIndexA,
      output result
   );
endinterface

// File: rtl/cl_mask_matcher.sv
// Selects the first two co-occupied positions of two 16-bit occupancy masks and
// reports their compressed indices and the resume point, registered once.
module cl_mask_matcher (
   input  logic              clock,
   input  logic              reset,
   cl_mask_matcher_if.slave  bus
);

   // Number of set bits of m strictly below dense position p.
   function automatic logic [4:0] count_below(input logic [15:0] m, input logic [4:0] p);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         if ((m[i] == 1'b1) && (5'(i) < p)) begin
            cnt = cnt + 5'd1;
         end else begin
            cnt = cnt;
         end
      end
      return cnt;
   endfunction

   logic [4:0]  start_w_s;
   logic [4:0]  start_a_s;
   logic [15:0] match_s;
   logic        found0_s;
   logic        found1_s;
   logic        more_s;
   logic [4:0]  p0_s;
   logic [4:0]  p1_s;
   logic [1:0]  num_s;
   logic [4:0]  next_s;
   logic [4:0]  k_w0_s;
   logic [4:0]  k_w1_s;
   logic [4:0]  k_a0_s;
   logic [4:0]  k_a1_s;
   logic [15:0] packed_w_s;
   logic [15:0] packed_a_s;
   logic [63:0] result_d;
   logic [63:0] result_q;

   // Eligibility, match vector and two-deep priority selection.
   always_comb begin
      start_w_s = (bus.startIndexW > 5'd16) ? 5'd16 : bus.startIndexW;
      start_a_s = (bus.startIndexA > 5'd16) ? 5'd16 : bus.startIndexA;
      match_s   = 16'h0000;
      found0_s  = 1'b0;
      found1_s  = 1'b0;
      more_s    = 1'b0;
      p0_s      = 5'd0;
      p1_s      = 5'd0;
      for (int i = 0; i < 16; i++) begin
         match_s[i] = bus.bitmaskW[i] & bus.bitmaskA[i] &
                      (5'(i) >= start_w_s) & (5'(i) >= start_a_s);
      end
      // Third and later matches only matter as "something remains after p1".
      for (int i = 0; i < 16; i++) begin
         if (match_s[i] == 1'b1) begin
            if (found0_s == 1'b0) begin
               found0_s = 1'b1;
               p0_s     = 5'(i);
            end else if (found1_s == 1'b0) begin
               found1_s = 1'b1;
               p1_s     = 5'(i);
            end else begin
               more_s   = 1'b1;
            end
         end else begin
            more_s = more_s;
         end
      end
   end

   // Compressed-index decode and result packing.
   always_comb begin
      k_w0_s     = count_below(bus.bitmaskW, p0_s);
      k_w1_s     = count_below(bus.bitmaskW, p1_s);
      k_a0_s     = count_below(bus.bitmaskA, p0_s);
      k_a1_s     = count_below(bus.bitmaskA, p1_s);
      packed_w_s = 16'h0000;
      packed_a_s = 16'h0000;
      if (found0_s == 1'b1) begin
         packed_w_s[k_w0_s[3:0]] = 1'b1;
         packed_a_s[k_a0_s[3:0]] = 1'b1;
      end else begin
         packed_w_s = 16'h0000;
      end
      if (found1_s == 1'b1) begin
         packed_w_s[k_w1_s[3:0]] = 1'b1;
         packed_a_s[k_a1_s[3:0]] = 1'b1;
      end else begin
         packed_a_s = packed_a_s;
      end
      num_s  = {1'b0, found0_s} + {1'b0, found1_s};
      next_s = (more_s == 1'b1) ? (p1_s + 5'd1) : 5'd16;
      result_d = {17'h00000, num_s, next_s, 1'b0, num_s, next_s, packed_a_s, packed_w_s};
   end

   // Output register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         result_q <= 64'h0000_0000_0000_0000;
      end else begin
         result_q <= result_d;
      end
   end

   assign bus.result = result_q;

endmodule

// File: tb/tb_cl_mask_matcher.sv
// Directed and randomized checks of cl_mask_matcher against a list-based model.
module tb_cl_mask_matcher;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   cl_mask_matcher_if bus ();

   cl_mask_matcher dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Model: collect all match positions in a list, then read off the rules.
   function automatic logic [63:0] ref_model(input logic [15:0] w, input logic [15:0] a,
                                             input logic [4:0] sw, input logic [4:0] sa);
      int          lo_w, lo_a, n, nxt, k;
      int          q[$];
      logic [15:0] below;
      logic [15:0] pk_w, pk_a;
      logic [63:0] r;
      lo_w = (sw > 16) ? 16 : int'(sw);
      lo_a = (sa > 16) ? 16 : int'(sa);
      for (int p = 0; p < 16; p++)
         if (w[p] && a[p] && p >= lo_w && p >= lo_a) q.push_back(p);
      n    = (q.size() > 2) ? 2 : q.size();
      pk_w = 16'h0;
      pk_a = 16'h0;
      for (int j = 0; j < n; j++) begin
         below = (16'h1 << q[j]) - 16'h1;
         k = $countones(w & below);
         pk_w[k] = 1'b1;
         k = $countones(a & below);
         pk_a[k] = 1'b1;
      end
      nxt = (q.size() > 2) ? q[1] + 1 : 16;
      r = 64'h0;
      r[15:0]  = pk_w;
      r[31:16] = pk_a;
      r[36:32] = 5'(nxt);
      r[38:37] = 2'(n);
      r[44:40] = 5'(nxt);
      r[46:45] = 2'(n);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] exp);
      total_cnt++;
      assert (bus.result === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, bus.result, exp);
   endtask

   task automatic drive(input logic [15:0] w, input logic [15:0] a,
                        input logic [4:0] sw, input logic [4:0] sa);
      bus.bitmaskW    = w;
      bus.bitmaskA    = a;
      bus.startIndexW = sw;
      bus.startIndexA = sa;
   endtask

   // Apply inputs, clock once, check the registered result.
   task automatic step(input string tag, input logic [15:0] w, input logic [15:0] a,
                       input logic [4:0] sw, input logic [4:0] sa, input logic [63:0] exp);
      drive(w, a, sw, sa);
      @(posedge clock);
      #1;
      check(tag, exp);
   endtask

   initial begin
      logic [15:0] w, a;
      logic [4:0]  sw, sa;
      // Reset with arbitrary inputs.
      drive(16'hFFFF, 16'hFFFF, 5'd0, 5'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      check("reset_c1", 64'h0);
      drive(16'h1234, 16'h00FF, 5'd3, 5'd1);
      @(posedge clock); #1;
      check("reset_c2", 64'h0);
      reset = 1'b0;

      // Directed vectors, first one loads with no bubble after reset.
      step("no_match",   16'hFFFF, 16'h0000, 5'd0, 5'd0, 64'h0000_1010_0000_0000);
      step("start_a4",   16'hFFFF, 16'hFFFF, 5'd0, 5'd4, 64'h0000_4646_0030_0030);
      step("low_pair",   16'hF00F, 16'hFFFF, 5'd0, 5'd0, 64'h0000_4242_0003_0003);
      step("edges",      16'h8001, 16'h8001, 5'd0, 5'd0, 64'h0000_5050_0003_0003);
      step("zero_masks", 16'h0000, 16'h0000, 5'd4, 5'd4, 64'h0000_1010_0000_0000);
      step("single",     16'h0F00, 16'h0100, 5'd0, 5'd0, ref_model(16'h0F00, 16'h0100, 5'd0, 5'd0));
      step("start16",    16'hFFFF, 16'hFFFF, 5'd16, 5'd0, 64'h0000_1010_0000_0000);
      step("start31",    16'hFFFF, 16'hFFFF, 5'd0, 5'd31, 64'h0000_1010_0000_0000);
      step("last_two",   16'hFFFF, 16'hFFFF, 5'd14, 5'd0, 64'h0000_5050_C000_C000);

      // Back-to-back nonzero vectors followed by a single-cycle reset pulse.
      step("b2b_0", 16'hFFFF, 16'hFFFF, 5'd0, 5'd4, 64'h0000_4646_0030_0030);
      step("b2b_1", 16'hF00F, 16'hFFFF, 5'd0, 5'd0, 64'h0000_4242_0003_0003);
      reset = 1'b1;
      step("mid_reset", 16'h8001, 16'h8001, 5'd0, 5'd0, 64'h0);
      reset = 1'b0;
      step("b2b_2", 16'h8001, 16'h8001, 5'd0, 5'd0, 64'h0000_5050_0003_0003);
      step("b2b_3", 16'hFFFF, 16'hFFFF, 5'd0, 5'd4, 64'h0000_4646_0030_0030);

      // Randomized vectors against the model, biased toward dense masks.
      for (int i = 0; i < 400; i++) begin
         w  = 16'($urandom) | ((i % 3 == 0) ? 16'($urandom) : 16'h0);
         a  = 16'($urandom) | ((i % 4 == 0) ? 16'($urandom) : 16'h0);
         sw = 5'($urandom_range(0, (i % 5 == 0) ? 31 : 16));
         sa = 5'($urandom_range(0, (i % 7 == 0) ? 31 : 16));
         step("random", w, a, sw, sa, ref_model(w, a, sw, sa));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
